// File: rtl/inv_drive_check_if.sv
// Bus between the inverter checker and whatever drives and observes it:
// the run handshake, the inverter drive and sense pins, and the run results.
`timescale 1ns/1ps
interface inv_drive_check_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             dut_in;
  logic             dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] first_fail_idx;

  // Checker side: drives the inverter and reports results.
  modport master (
    input  start, dut_out,
    output dut_in, busy, done, pass, err_count, vec_count, first_fail_idx
  );

  // Environment side: requests runs, closes the loop through the cell.
  modport slave (
    output start, dut_out,
    input  dut_in, busy, done, pass, err_count, vec_count, first_fail_idx
  );
endinterface

// File: rtl/inv_drive_check.sv
// Driver/monitor for a static CMOS inverter cell. Each vector drives one
// LFSR bit, waits a programmable settle time, then samples the cell output
// and checks it is the complement of the driven bit. Any X/Z on the sense
// pin counts as a mismatch.
`timescale 1ns/1ps
module inv_drive_check #(
  parameter int         NUM_VECTORS = 16,
  parameter int         SETTLE      = 2,
  parameter logic [7:0] SEED        = 8'h01,
  parameter int         CNT_W       = 8
) (
  input logic                clk,
  input logic                rst_n,
  inv_drive_check_if.master  bus
);

  // An all-zero Fibonacci LFSR would lock up, so a zero seed becomes 01.
  localparam logic [7:0]       SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [CNT_W-1:0] NV        = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       lfsr;
  logic [3:0]       settle_cnt;
  logic             dut_in_r;
  logic             pass_r;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] ff_idx;
  logic [CNT_W-1:0] vec_inc;
  logic             mismatch;
  logic             busy_c;
  logic             done_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  assign vec_inc  = vec_cnt + 1'b1;
  // Case inequality so an undriven or unknown output is flagged, not hidden.
  assign mismatch = (bus.dut_out !== ~dut_in_r);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and the status strobes derived from the state.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b1;
    done_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_nxt = ST_DRIVE;
      end
      ST_DRIVE:  state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == 4'd0) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = (vec_inc == NV) ? ST_DONE : ST_DRIVE;
      ST_DONE: begin
        done_c    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Run bookkeeping: drive bit, LFSR, error/vector counters and verdict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr     <= SEED_EFF;
      dut_in_r <= 1'b0;
      pass_r   <= 1'b0;
      err_cnt  <= '0;
      vec_cnt  <= '0;
      ff_idx   <= CNT_MAX;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            err_cnt <= '0;
            vec_cnt <= '0;
            ff_idx  <= CNT_MAX;
            pass_r  <= 1'b0;
          end
        end
        ST_DRIVE: dut_in_r <= lfsr[0];
        ST_SAMPLE: begin
          if (mismatch) begin
            err_cnt <= sat_inc(err_cnt);
            if (ff_idx == CNT_MAX) ff_idx <= vec_cnt;
          end
          vec_cnt <= vec_inc;
          lfsr    <= lfsr_step(lfsr);
        end
        ST_DONE: pass_r <= (err_cnt == '0);
        default: ;
      endcase
    end
  end

  // Settle timer: loaded while driving so SETTLE counts whole cycles after it.
  always_ff @(posedge clk) begin
    if (state == ST_DRIVE)                           settle_cnt <= SETTLE_LD;
    else if (state == ST_SETTLE && settle_cnt != 0)  settle_cnt <= settle_cnt - 4'd1;
  end

  assign bus.dut_in         = dut_in_r;
  assign bus.busy           = busy_c;
  assign bus.done           = done_c;
  assign bus.pass           = pass_r;
  assign bus.err_count      = err_cnt;
  assign bus.vec_count      = vec_cnt;
  assign bus.first_fail_idx = ff_idx;

endmodule

// File: tb/tb_inv_drive_check.sv
// Bench for inv_drive_check: two checker instances (16 vectors / settle 2
// with seed 01, and 6 vectors / settle 1 with a zero seed) closed through
// behavioural inverter models. A run planner predicts every vector and run
// result into queues; a negedge monitor pops and compares as the DUTs report.
`timescale 1ns/1ps
module tb_inv_drive_check;

  localparam int NV_A = 16;
  localparam int ST_A = 2;
  localparam int NV_B = 6;
  localparam int ST_B = 1;

  typedef struct packed {
    logic       d;
    logic [7:0] err;
  } vexp_t;

  typedef struct packed {
    logic [7:0]  err;
    logic [7:0]  vec;
    logic [7:0]  ff;
    logic        pass;
    logic [31:0] done_cyc;
  } rexp_t;

  typedef struct packed {
    logic       busy;
    logic       dut_in;
    logic       done;
    logic       pass;
    logic [7:0] err;
    logic [7:0] vec;
    logic [7:0] ff;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start_r = 2'b00;
  int         mode [2] = '{0, 0};
  logic       xbit;
  logic       da3, db3, db30;
  logic       out_a, out_b;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  vexp_t      vq [2][$];
  rexp_t      rq [2][$];
  snap_t      sq [2][$];
  snap_t      obs [2];
  logic [1:0] pend_pass = 2'b00;
  logic [1:0] pass_exp = 2'b00;
  logic [7:0] prev_vec [2] = '{8'h00, 8'h00};
  logic [7:0] lfsr_m [2] = '{8'h01, 8'h01};
  logic [1:0] prev_m = 2'b00;

  inv_drive_check_if #(.CNT_W(8)) ifa ();
  inv_drive_check_if #(.CNT_W(8)) ifb ();

  inv_drive_check #(.NUM_VECTORS(NV_A), .SETTLE(ST_A), .SEED(8'h01), .CNT_W(8))
    u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  inv_drive_check #(.NUM_VECTORS(NV_B), .SETTLE(ST_B), .SEED(8'h00), .CNT_W(8))
    u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inverter models: ideal, stuck-at-0, floating (X), and transport-delayed.
  always @(ifa.dut_in) da3  <= #3  ~ifa.dut_in;
  always @(ifb.dut_in) db3  <= #3  ~ifb.dut_in;
  always @(ifb.dut_in) db30 <= #30 ~ifb.dut_in;

  always_comb begin
    case (mode[0])
      1:       out_a = 1'b0;
      2:       out_a = xbit;
      3:       out_a = da3;
      default: out_a = ~ifa.dut_in;
    endcase
    case (mode[1])
      1:       out_b = 1'b0;
      2:       out_b = xbit;
      3:       out_b = db3;
      4:       out_b = db30;
      default: out_b = ~ifb.dut_in;
    endcase
  end

  assign ifa.start   = start_r[0];
  assign ifb.start   = start_r[1];
  assign ifa.dut_out = out_a;
  assign ifb.dut_out = out_b;

  always_comb begin
    obs[0] = {ifa.busy, ifa.dut_in, ifa.done, ifa.pass,
              ifa.err_count, ifa.vec_count, ifa.first_fail_idx};
    obs[1] = {ifb.busy, ifb.dut_in, ifb.done, ifb.pass,
              ifb.err_count, ifb.vec_count, ifb.first_fail_idx};
  end

  task automatic chk(input string name, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, inst, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Predict a whole run: the driven bit sequence comes from the LFSR rule,
  // a vector fails when the modelled cell output is not the complement.
  // The 30 ns cell with settle 1 is still showing the previous drive when
  // sampled 20 ns after a change, so it fails exactly when the bit changes.
  task automatic plan_run(input int i, input int md, input int st_cyc);
    int    nv, st, err, ff;
    logic  d, bad;
    vexp_t v;
    rexp_t r;
    nv  = (i == 0) ? NV_A : NV_B;
    st  = (i == 0) ? ST_A : ST_B;
    err = 0;
    ff  = -1;
    for (int k = 0; k < nv; k++) begin
      d = lfsr_m[i][0];
      case (md)
        1:       bad = (d == 1'b0);
        2:       bad = (xbit !== ~d);
        4:       bad = (d != prev_m[i]);
        default: bad = 1'b0;
      endcase
      if (bad) begin
        if (err < 255) err++;
        if (ff < 0) ff = k;
      end
      v.d   = d;
      v.err = 8'(err);
      vq[i].push_back(v);
      prev_m[i] = d;
      lfsr_m[i] = {lfsr_m[i][6:0], ^(lfsr_m[i] & 8'hB8)};
    end
    r.err      = 8'(err);
    r.vec      = 8'(nv);
    r.ff       = (ff < 0) ? 8'hFF : 8'(ff);
    r.pass     = (err == 0);
    r.done_cyc = 32'(st_cyc + nv * (st + 2));
    rq[i].push_back(r);
  endtask

  task automatic launch(input int i, input int md);
    mode[i] = md;
    plan_run(i, md, cyc + 1);
    start_r[i] = 1'b1;
    tick();
    start_r[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while ((rq[i].size() != 0 || pend_pass[i]) && n < 600) begin
      tick();
      n++;
    end
    chk("run_completed", i, (rq[i].size() == 0 && !pend_pass[i]), 1);
    chk("vectors_drained", i, vq[i].size(), 0);
  endtask

  task automatic wait_vec(input int i, input logic [7:0] target);
    int n = 0;
    while (obs[i].vec != target && n < 200) begin
      tick();
      n++;
    end
    chk("reach_vector", i, obs[i].vec, target);
  endtask

  task automatic do_reset();
    snap_t s;
    rst_n = 1'b0;
    start_r = 2'b00;
    tick();
    rst_n = 1'b1;
    s = {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF};
    for (int i = 0; i < 2; i++) begin
      vq[i].delete();
      rq[i].delete();
      sq[i].push_back(s);
      lfsr_m[i] = 8'h01;
    end
    pend_pass = 2'b00;
    prev_m    = 2'b00;
    tick();
  endtask

  // Monitor: pops expectations whenever a DUT reports a vector or a run end.
  always @(negedge clk) begin
    vexp_t v;
    rexp_t r;
    snap_t s;
    for (int i = 0; i < 2; i++) begin
      if (rst_n) begin
        if (pend_pass[i]) begin
          chk("pass", i, obs[i].pass, pass_exp[i]);
          chk("done_one_cycle", i, obs[i].done, 1'b0);
          chk("busy_falls_with_done", i, obs[i].busy, 1'b0);
          pend_pass[i] = 1'b0;
        end
        if (obs[i].vec != prev_vec[i] && obs[i].vec != 8'h00) begin
          if (vq[i].size() == 0) chk("unexpected_vector", i, 1, 0);
          else begin
            v = vq[i].pop_front();
            chk("dut_in", i, obs[i].dut_in, v.d);
            chk("err_running", i, obs[i].err, v.err);
          end
        end
        if (obs[i].done) begin
          if (rq[i].size() == 0) chk("unexpected_done", i, 1, 0);
          else begin
            r = rq[i].pop_front();
            chk("err_count", i, obs[i].err, r.err);
            chk("vec_count", i, obs[i].vec, r.vec);
            chk("first_fail_idx", i, obs[i].ff, r.ff);
            chk("done_cycle", i, cyc, r.done_cyc);
            chk("busy_in_done", i, obs[i].busy, 1'b1);
            pend_pass[i] = 1'b1;
            pass_exp[i]  = r.pass;
          end
        end
      end
      if (sq[i].size() != 0) begin
        s = sq[i].pop_front();
        chk("snap_busy", i, obs[i].busy, s.busy);
        chk("snap_dut_in", i, obs[i].dut_in, s.dut_in);
        chk("snap_done", i, obs[i].done, s.done);
        chk("snap_pass", i, obs[i].pass, s.pass);
        chk("snap_err", i, obs[i].err, s.err);
        chk("snap_vec", i, obs[i].vec, s.vec);
        chk("snap_ff", i, obs[i].ff, s.ff);
      end
      prev_vec[i] = obs[i].vec;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    xbit = 1'bx;
    repeat (3) tick();
    do_reset();

    // Ideal cell, 16 vectors: sequence 1,0,0,0,1,1,... and a clean pass.
    launch(0, 0);
    wait_idle(0);

    // Stuck-at-0, floating, then 3 ns and 30 ns cells on the 6-vector unit.
    launch(1, 1);
    wait_idle(1);
    launch(1, 2);
    wait_idle(1);
    launch(1, 3);
    wait_idle(1);
    launch(1, 4);
    wait_idle(1);
    chk("slow_cell_errors", 1, (ifb.err_count != 8'h00), 1);

    // Start pulsed again mid-run must be ignored.
    launch(0, 0);
    wait_vec(0, 8'd5);
    start_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    wait_idle(0);

    // Start held high: back-to-back runs, the second one IDLE cycle later.
    mode[1] = 0;
    plan_run(1, 0, cyc + 1);
    plan_run(1, 0, cyc + 1 + NV_B * (ST_B + 2) + 2);
    start_r[1] = 1'b1;
    for (int n = 0; n < 200 && rq[1].size() > 1; n++) tick();
    repeat (3) tick();
    start_r[1] = 1'b0;
    wait_idle(1);

    // Reset while settling vector 3, then a replay from seed.
    launch(0, 0);
    wait_vec(0, 8'd3);
    tick();
    do_reset();
    launch(0, 0);
    wait_idle(0);

    // Randomised runs across both units and all cell models.
    for (int it = 0; it < 10; it++) begin
      int inst, md;
      inst = int'($urandom_range(0, 1));
      md   = (inst == 1) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 4)) tick();
      launch(inst, md);
      wait_idle(inst);
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_drive_check.md
Name: inv_drive_check

Overview:
- Self-checking driver/monitor for a static CMOS inverter cell.
- Upstream role: generates a pseudo-random stimulus on the inverter input.
- Downstream role: samples the inverter output after a programmable settle time and checks it against the logical complement of the driven value.
- Lives in the bench/characterisation layer around switch-level cells. Reports error count, pass/fail and the first failing vector.

Parameters:
- NUM_VECTORS, 16: vectors per run, range 1..255.
- SETTLE, 2: clock cycles between driving and sampling, range 1..15.
- SEED, 8'h01: LFSR start value. A value of 0 is forced to 8'h01.
- CNT_W, 8: width of the counters and the index output.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- start  input  1  begin a run; sampled only in IDLE
- dut_in  output  1  drive to the inverter input
- dut_out  input  1  inverter output being checked
- busy  output  1  high while a run is active
- done  output  1  one-cycle pulse at the end of a run
- pass  output  1  high when the last run had err_count==0; held until the next start
- err_count  output  CNT_W  mismatches in the current/last run; saturates at all-ones
- vec_count  output  CNT_W  vectors sampled in the current/last run
- first_fail_idx  output  CNT_W  index of the first mismatching vector; all-ones if none

Behaviour:
- One clock domain. All state updates on the rising clk edge.
- Reset (rst_n==0 at the edge), from any state, including mid-run:
  - state=IDLE; dut_in=0; busy=0; done=0; pass=0.
  - err_count=0; vec_count=0; first_fail_idx=all-ones.
  - lfsr=SEED, or 8'h01 if SEED==0.
- LFSR:
  - 8-bit Fibonacci, shift left: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - The driven bit is lfsr[0].
  - Advances once per SAMPLE.
- IDLE:
  - busy=0.
  - On start=1: clear err_count and vec_count, set first_fail_idx=all-ones, clear pass, go to DRIVE.
  - The LFSR is not reseeded between runs; it continues from its current value.
- DRIVE (1 cycle):
  - dut_in <= lfsr[0]; load settle counter with SETTLE-1; go to SETTLE. busy=1.
- SETTLE:
  - dut_in held.
  - Counter decrements each cycle. When it reaches 0, go to SAMPLE.
  - Total time in SETTLE is SETTLE cycles.
- SAMPLE (1 cycle):
  - Mismatch when dut_out !== ~dut_in (case inequality), so X or Z on dut_out counts as an error.
  - On mismatch:
    - err_count increments, saturating at all-ones.
    - If first_fail_idx is all-ones, it is set to vec_count.
  - vec_count increments and the LFSR advances.
  - If the new vec_count == NUM_VECTORS, go to DONE; otherwise go to DRIVE.
- DONE (1 cycle):
  - done=1; pass <= (err_count==0); busy=1 this cycle. Then go to IDLE.
  - dut_in keeps its last value until the next DRIVE.
- Latency:
  - Each vector takes SETTLE+2 cycles.
  - A run takes NUM_VECTORS*(SETTLE+2) cycles from the start edge, plus 1 DONE cycle.
- Boundary cases:
  - start while busy: ignored, no restart.
  - start held high: a new run begins on the first IDLE cycle after DONE.
  - Counters never wrap: err_count saturates, and vec_count is bounded by NUM_VECTORS.
  - done and busy fall together on the cycle after DONE.

Test Plan:
- Ideal inverter model, NUM_VECTORS=16, SETTLE=2, SEED=01, pulse start:
  - dut_in sequence begins 1,0,0,0,1,1.
  - done pulses 65 cycles after the start edge.
  - pass=1, err_count=0, vec_count=16, first_fail_idx=8'hFF.
- dut_out tied to 0 (stuck-at-0), NUM_VECTORS=6:
  - Errors on each dut_in=0 vector.
  - err_count=3, first_fail_idx=1, pass=0.
- dut_out undriven (Z), NUM_VECTORS=6:
  - err_count=6, first_fail_idx=0, pass=0.
- Delayed inverter (#3 ns, clk period 10 ns) with SETTLE=1:
  - Passes, pass=1.
- Same delayed inverter with a 30 ns delay and SETTLE=1:
  - err_count>0.
- Assert rst_n=0 for one cycle during SETTLE of vector 3:
  - Next cycle: busy=0, dut_in=0, err_count=0, vec_count=0, lfsr=01.
  - A subsequent start replays the sequence from 1,0,0,0.
- Pulse start again while busy at vector 5:
  - No effect; run completes with vec_count=16 and a single done pulse.
